// File: rtl/surf_dout_pkg.sv
// Shared constants, state encoding and header byte mapping for the SURF dout event transmitter.
package surf_dout_pkg;

  localparam int NUM_CH     = 8;
  localparam int CH_BYTES   = 1536;
  localparam int HDR_BYTES  = 4;
  localparam int NUM_BYTES  = NUM_CH * CH_BYTES + HDR_BYTES;
  localparam int BYTE_CNT_W = $clog2(NUM_BYTES);
  localparam int TTIME_W    = 15;
  localparam int AUX_W      = 16;
  localparam int HOLD_W     = 24;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNDR = 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    HOLDOFF
  } state_t;

  // byte0 carries the start marker in bit 7
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx,
                                          input logic [TTIME_W-1:0] ttime,
                                          input logic [AUX_W-1:0] aux);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {1'b1, ttime[14:8]};
      2'd1:    b = ttime[7:0];
      2'd2:    b = aux[15:8];
      default: b = aux[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/surf_trig_queue.sv
// Trigger-time FIFO: first-word-fall-through read, push and pop honoured together, overflow pulse on drop.
module surf_trig_queue #(
  parameter int DEPTH = 16,
  parameter int W     = 15
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push while full is still accepted
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/surf_dout_event_tx.sv
// SURF dout event transmitter: per trigger, 4 header bytes + 12288 data bytes, then read holdoff.
// Ramp test pattern is built only when SURF_TX_TESTPATTERN_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a queued trigger time
// HEADER  | emitting header bytes 0..3
// DATA    | emitting data bytes 4..12291 from s_data (or the ramp)
// HOLDOFF | silent for rdholdoff_i+1 strobes before the next event
module surf_dout_event_tx
  import surf_dout_pkg::*;
#(
  parameter int    TRIG_FIFO_DEPTH = 16,
  parameter string DEBUG           = "FALSE"
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               dout_ce_i,
  input  logic               trig_i,
  input  logic [TTIME_W-1:0] trig_time_i,
  input  logic [AUX_W-1:0]   hdr_aux_i,
  input  logic [HOLD_W-1:0]  rdholdoff_i,
  input  logic               test_pattern_i,
  input  logic [7:0]         s_data_tdata,
  input  logic               s_data_tvalid,
  output logic               s_data_tready,
  output logic [7:0]         m_dout_tdata,
  output logic               m_dout_tvalid,
  output logic               busy_o,
  output logic [1:0]         err_o
);

  state_t                 state;
  state_t                 state_nxt;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [HOLD_W:0]        hold_cnt;
  logic [TTIME_W-1:0]     ttime_q;
  logic [AUX_W-1:0]       aux_q;
  logic [TTIME_W-1:0]     q_dout;
  logic                   q_pop;
  logic                   q_empty;
  logic                   q_ovf;
  logic                   unused_q_full;
  logic                   emit;
  logic                   data_done;
  logic                   undr;
  logic [7:0]             byte_nxt;
  logic                   tp_q;
  logic [7:0]             ramp_byte;

  surf_trig_queue #(
    .DEPTH (TRIG_FIFO_DEPTH),
    .W     (TTIME_W)
  ) u_trig_queue (
    .aclk     (aclk),
    .areset   (areset),
    .push     (trig_i),
    .din      (trig_time_i),
    .pop      (q_pop),
    .dout     (q_dout),
    .empty    (q_empty),
    .full     (unused_q_full),
    .overflow (q_ovf)
  );

  assign emit          = dout_ce_i & ((state == HEADER) | (state == DATA));
  assign data_done     = dout_ce_i & (state == DATA) & (byte_cnt == BYTE_CNT_W'(NUM_BYTES - 1));
  assign s_data_tready = dout_ce_i & (state == DATA) & ~tp_q;
  assign undr          = s_data_tready & ~s_data_tvalid;
  assign busy_o        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          state_nxt = HEADER;
          q_pop     = 1'b1;
        end
      end
      HEADER:  if (dout_ce_i && byte_cnt == BYTE_CNT_W'(HDR_BYTES - 1)) state_nxt = DATA;
      DATA:    if (data_done) state_nxt = HOLDOFF;
      HOLDOFF: if (hold_cnt[HOLD_W]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_nxt = 8'h00;
    if (state == HEADER)    byte_nxt = hdr_byte(byte_cnt[1:0], ttime_q, aux_q);
    else if (tp_q)          byte_nxt = ramp_byte;
    else if (s_data_tvalid) byte_nxt = s_data_tdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      hold_cnt      <= '0;
      ttime_q       <= '0;
      aux_q         <= '0;
      m_dout_tdata  <= 8'h00;
      m_dout_tvalid <= 1'b0;
      err_o         <= 2'b00;
    end else begin
      state         <= state_nxt;
      m_dout_tvalid <= emit;
      if (emit) m_dout_tdata <= byte_nxt;
      if (q_pop) begin
        ttime_q  <= q_dout;
        aux_q    <= hdr_aux_i;
        byte_cnt <= '0;
      end else if (emit) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      // bit HOLD_W flags the borrow: rdholdoff_i+1 decrements reach it
      if (data_done) begin
        hold_cnt <= {1'b0, rdholdoff_i};
      end else if (state == HOLDOFF && dout_ce_i && !hold_cnt[HOLD_W]) begin
        hold_cnt <= {1'b0, hold_cnt[HOLD_W-1:0]} - 1'b1;
      end
      if (q_ovf) err_o[ERR_OVF]  <= 1'b1;
      if (undr)  err_o[ERR_UNDR] <= 1'b1;
    end
  end

`ifdef SURF_TX_TESTPATTERN_EN
  logic [11:0] ramp_s0;
  logic [11:0] ramp_s1;
  logic [1:0]  ramp_ph;

  assign ramp_s1 = ramp_s0 + 12'd1;

  // two 12-bit samples packed into three bytes
  always_comb begin
    case (ramp_ph)
      2'd0:    ramp_byte = ramp_s0[7:0];
      2'd1:    ramp_byte = {ramp_s1[3:0], ramp_s0[11:8]};
      default: ramp_byte = ramp_s1[11:4];
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tp_q    <= 1'b0;
      ramp_s0 <= '0;
      ramp_ph <= '0;
    end else if (q_pop) begin
      tp_q    <= test_pattern_i;
      ramp_s0 <= '0;
      ramp_ph <= '0;
    end else if (tp_q && dout_ce_i && state == DATA) begin
      if (ramp_ph == 2'd2) begin
        ramp_ph <= '0;
        ramp_s0 <= ramp_s0 + 12'd2;
      end else begin
        ramp_ph <= ramp_ph + 1'b1;
      end
    end
  end
`else
  logic unused_tp;
  assign tp_q      = 1'b0;
  assign ramp_byte = 8'h00;
  assign unused_tp = test_pattern_i;
`endif

  if (DEBUG == "TRUE") begin : g_dbg
    (* mark_debug = "true" *) logic [2+BYTE_CNT_W+HOLD_W:0] dbg_probe;
    assign dbg_probe = {state, byte_cnt, hold_cnt};
  end

endmodule

// File: tb/tb_surf_dout_event_tx.sv
// Scoreboard bench for surf_dout_event_tx: expected bytes queued at trigger time, monitor pops on tvalid.
module tb_surf_dout_event_tx;
  import surf_dout_pkg::*;

  localparam int DEPTH  = 2;
  localparam int DBYTES = NUM_BYTES - HDR_BYTES;
  localparam int UND_LO = 2 * DBYTES + 100;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        dout_ce_i = 1'b0;
  logic        trig_i = 1'b0;
  logic [14:0] trig_time_i = '0;
  logic [15:0] hdr_aux_i = '0;
  logic [23:0] rdholdoff_i = '0;
  logic        test_pattern_i = 1'b0;
  logic [7:0]  s_data_tdata;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [7:0]  m_dout_tdata;
  logic        m_dout_tvalid;
  logic        busy_o;
  logic [1:0]  err_o;

  surf_dout_event_tx #(
    .TRIG_FIFO_DEPTH (DEPTH),
    .DEBUG           ("FALSE")
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .dout_ce_i      (dout_ce_i),
    .trig_i         (trig_i),
    .trig_time_i    (trig_time_i),
    .hdr_aux_i      (hdr_aux_i),
    .rdholdoff_i    (rdholdoff_i),
    .test_pattern_i (test_pattern_i),
    .s_data_tdata   (s_data_tdata),
    .s_data_tvalid  (s_data_tvalid),
    .s_data_tready  (s_data_tready),
    .m_dout_tdata   (m_dout_tdata),
    .m_dout_tvalid  (m_dout_tvalid),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 aclk = ~aclk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         ev_idx = 0;
  int         events_done = 0;
  int         silent = 0;
  int         hold_exp = 0;
  int         src_n = 0;
  int         dj = 0;
  int         gen_src = 0;
  bit         tp_mode = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] src_byte(int n);
    return 8'((n * 37 + 11) % 256);
  endfunction

  function automatic logic [7:0] ramp_exp(int j);
    int p;
    logic [11:0] s0;
    logic [11:0] s1;
    p  = j / 3;
    s0 = 12'((2 * p) % 4096);
    s1 = 12'((2 * p + 1) % 4096);
    case (j % 3)
      0:       return s0[7:0];
      1:       return {s1[3:0], s0[11:8]};
      default: return s1[11:4];
    endcase
  endfunction

  task automatic push_event(logic [14:0] tt, logic [15:0] aux, bit under, bit tp);
    exp_q.push_back({1'b1, tt[14:8]});
    exp_q.push_back(tt[7:0]);
    exp_q.push_back(aux[15:8]);
    exp_q.push_back(aux[7:0]);
    for (int j = 0; j < DBYTES; j++) begin
      if (tp) exp_q.push_back(ramp_exp(j));
      else if (under && j >= 100 && j < 105) exp_q.push_back(8'h00);
      else begin
        exp_q.push_back(src_byte(gen_src));
        gen_src++;
      end
    end
  endtask

  task automatic wait_events(int n, int budget);
    int cyc;
    cyc = 0;
    while (!(events_done >= n && !busy_o) && cyc < budget) begin
      @(negedge aclk);
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL wait_events: events got %0d want %0d", events_done, n);
    end
  endtask

  task automatic pulse_trig(logic [14:0] tt);
    @(posedge aclk); #1;
    trig_i = 1'b1;
    trig_time_i = tt;
    @(posedge aclk); #1;
    trig_i = 1'b0;
  endtask

  // byte strobe: every clock in the middle of the data phase, every 4 clocks elsewhere
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge aclk); #1;
      if (ev_idx >= 4 && ev_idx < DBYTES) begin
        dout_ce_i = 1'b1;
        ph = 0;
      end else begin
        dout_ce_i = (ph == 0);
        ph = (ph + 1) % 4;
      end
    end
  end

  // readout buffer model with a 5-strobe underrun window in the third event
  initial begin
    s_data_tvalid = 1'b1;
    s_data_tdata  = src_byte(0);
    forever begin
      @(negedge aclk);
      if (areset) dj = 0;
      else if (s_data_tready) begin
        if (s_data_tvalid) src_n++;
        dj++;
      end
      @(posedge aclk); #1;
      s_data_tvalid = !(dj >= UND_LO && dj < UND_LO + 5);
      s_data_tdata  = s_data_tvalid ? src_byte(src_n) : 8'hA5;
    end
  end

  initial begin
    logic [7:0] e;
    bit pend_ce;
    bit busy_d;
    pend_ce = 1'b0;
    busy_d  = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete();
        ev_idx  = 0;
        silent  = 0;
        pend_ce = 1'b0;
        busy_d  = 1'b0;
        continue;
      end
      if (m_dout_tvalid) begin
        if (ev_idx == 0) silent = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h want none", m_dout_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_dout_tdata !== e) $display("FAIL byte[%0d] ev%0d: got %0h want %0h", ev_idx, events_done, m_dout_tdata, e);
          total++;
          if (m_dout_tdata !== e) bad++;
        end
        ev_idx = (ev_idx + 1) % NUM_BYTES;
        if (ev_idx == 0) events_done++;
      end else if (pend_ce) begin
        silent++;
      end
      if (tp_mode) chk("tready_in_tp", s_data_tready, 0);
      if (busy_d && !busy_o) chk("holdoff_gap", silent, hold_exp + 1);
      busy_d  = busy_o;
      pend_ce = dout_ce_i;
    end
  end

  initial begin
    int cyc;
    int ev0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", m_dout_tvalid, 0);
    chk("rst_tdata", m_dout_tdata, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_tready", s_data_tready, 0);
    areset = 1'b0;

    // single event, holdoff 10
    hold_exp    = 10;
    rdholdoff_i = 24'd10;
    hdr_aux_i   = 16'hBEEF;
    push_event(15'h1234, 16'hBEEF, 1'b0, 1'b0);
    pulse_trig(15'h1234);
    wait_events(1, 60000);
    chk("t1_err", err_o, 0);

    // four triggers in consecutive cycles at depth 2: one dropped, underrun in the second event
    hold_exp    = 3;
    rdholdoff_i = 24'd3;
    hdr_aux_i   = 16'h1234;
    push_event(15'h0001, 16'h1234, 1'b0, 1'b0);
    push_event(15'h7F7F, 16'h1234, 1'b1, 1'b0);
    push_event(15'h4A5B, 16'h1234, 1'b0, 1'b0);
    @(posedge aclk); #1;
    trig_i = 1'b1;
    trig_time_i = 15'h0001;
    @(posedge aclk); #1;
    trig_time_i = 15'h7F7F;
    @(posedge aclk); #1;
    trig_time_i = 15'h4A5B;
    @(posedge aclk); #1;
    trig_time_i = 15'h1111;
    @(posedge aclk); #1;
    trig_i = 1'b0;
    @(negedge aclk);
    chk("ovf_flag", err_o[ERR_OVF], 1);
    chk("no_undr_yet", err_o[ERR_UNDR], 0);
    wait_events(4, 60000);
    repeat (200) @(negedge aclk);
    chk("events_after_ovf", events_done, 4);
    chk("busy_after_ovf", busy_o, 0);
    chk("err_sticky", err_o, 2'b11);
    chk("queue_drained", exp_q.size(), 0);

    // reset in the middle of an event
    hold_exp    = 5;
    rdholdoff_i = 24'd5;
    hdr_aux_i   = 16'h0102;
    push_event(15'h0ABC, 16'h0102, 1'b0, 1'b0);
    pulse_trig(15'h0ABC);
    cyc = 0;
    while (ev_idx != 6000 && cyc < 20000) begin
      @(negedge aclk);
      cyc++;
    end
    chk("reach_6000_timeout", (cyc >= 20000), 0);
    #1 areset = 1'b1;
    #2;
    chk("abort_tvalid", m_dout_tvalid, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_err", err_o, 0);
    chk("abort_tready", s_data_tready, 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    gen_src   = src_n;
    hdr_aux_i = 16'h7E7E;
    ev0 = events_done;
    push_event(15'h0321, 16'h7E7E, 1'b0, 1'b0);
    pulse_trig(15'h0321);
    wait_events(ev0 + 1, 60000);
    chk("post_rst_err", err_o, 0);

`ifdef SURF_TX_TESTPATTERN_EN
    ev0 = events_done;
    test_pattern_i = 1'b1;
    tp_mode = 1'b1;
    push_event(15'h0055, 16'h7E7E, 1'b0, 1'b1);
    pulse_trig(15'h0055);
    wait_events(ev0 + 1, 60000);
    tp_mode = 1'b0;
    test_pattern_i = 1'b0;
    chk("tp_err", err_o, 0);
`endif

    repeat (20) @(negedge aclk);
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
